bg_scroll_addr: RTL and testbench

//  Consumes the BG_EN strobe from the background sequencer and turns it into a

---
 rtl/bg_scroll_addr_if.sv | 34 +++
 rtl/bg_scroll_addr.sv | 142 ++++++++++++++
 tb/tb_bg_scroll_addr.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/bg_scroll_addr_if.sv
`default_nettype none
// ============================================================================
//  Module      : bg_scroll_addr_if
//  Description : Bundles the sequencer, VGA-position and ROM-address signals
//                of the background scroll/address block.
//                master : drives BG_EN, scroll_run, frame_start, pix_valid,
//                         DrawX, DrawY; observes bg_addr, addr_valid, scroll_off
//                slave  : the bg_scroll_addr block (mirror of master)
//  Revision    : 1.0  initial release
// ============================================================================
interface bg_scroll_addr_if #(
  parameter int ADDR_W = 17
);
  logic              BG_EN;
  logic              scroll_run;
  logic              frame_start;
  logic              pix_valid;
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic [ADDR_W-1:0] bg_addr;
  logic              addr_valid;
  logic [8:0]        scroll_off;

  modport master (
    output BG_EN, scroll_run, frame_start, pix_valid, DrawX, DrawY,
    input  bg_addr, addr_valid, scroll_off
  );

  modport slave (
    input  BG_EN, scroll_run, frame_start, pix_valid, DrawX, DrawY,
    output bg_addr, addr_valid, scroll_off
  );
endinterface
`default_nettype wire

// File: rtl/bg_scroll_addr.sv
`default_nettype none
// ============================================================================
//  Module      : bg_scroll_addr
//  Description : Counts BG_EN rising edges into a frame-synchronous vertical
//                scroll offset and maps DrawX/DrawY to a background ROM
//                address with that offset applied (2-cycle pipeline).
//  Ports       : Clk, Reset (sync, active-high)
//                bus (slave): BG_EN, scroll_run, frame_start, pix_valid,
//                DrawX, DrawY in; bg_addr, addr_valid, scroll_off out
//  Revision    : 1.0  initial release
// ============================================================================
module bg_scroll_addr #(
  parameter int IMG_W          = 320,
  parameter int IMG_H          = 240,
  parameter int SHIFT          = 1,
  parameter int STEP           = 1,
  parameter int TICKS_PER_STEP = 2,
  parameter int ADDR_W         = 17
) (
  input  logic             Clk,
  input  logic             Reset,
  bg_scroll_addr_if.slave  bus
);

  localparam int TCW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [TCW-1:0]    C_TC_LAST = TCW'(TICKS_PER_STEP - 1);
  localparam logic [9:0]        C_STEP    = 10'(STEP);
  localparam logic [9:0]        C_IMGH10  = 10'(IMG_H);
  localparam logic [10:0]       C_IMGH11  = 11'(IMG_H);
  localparam logic [9:0]        C_IMGW10  = 10'(IMG_W);
  localparam logic [ADDR_W-1:0] C_IMGW_A  = ADDR_W'(IMG_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              bg_en_q;
  logic [TCW-1:0]    tick_cnt_q, tick_cnt_d;
  logic [8:0]        pending_q, pending_d;
  logic [8:0]        scroll_off_q;
  logic [9:0]        pend_sum;
  logic              tick;

  // Pipeline
  logic [9:0]        xdown, ydown;
  logic [10:0]       row_sum;
  logic [8:0]        row_w;
  logic              v1_w;
  logic [9:0]        col_q;
  logic [8:0]        row_q;
  logic              v1_q;
  logic [ADDR_W-1:0] bg_addr_q;
  logic              addr_valid_q;

  assign tick = bus.BG_EN & ~bg_en_q;

  // Next-state: FSM transitions plus the tick counter / pending offset,
  // which only advance while the FSM is in RUN.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    pending_d  = pending_q;
    pend_sum   = {1'b0, pending_q} + C_STEP;
    case (state_q)
      IDLE: begin
        if (bus.frame_start) state_d = RUN;
      end
      RUN: begin
        if (!bus.scroll_run) state_d = HOLD;
        if (tick) begin
          if (tick_cnt_q == C_TC_LAST) begin
            tick_cnt_d = '0;
            // STEP < IMG_H, so one subtract brings the sum back in range.
            pending_d  = (pend_sum >= C_IMGH10) ? 9'(pend_sum - C_IMGH10)
                                                : pend_sum[8:0];
          end else begin
            tick_cnt_d = tick_cnt_q + TCW'(1);
          end
        end
      end
      HOLD: begin
        if (bus.scroll_run) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      bg_en_q      <= 1'b0;
      tick_cnt_q   <= '0;
      pending_q    <= '0;
      scroll_off_q <= '0;
    end else begin
      state_q    <= state_d;
      bg_en_q    <= bus.BG_EN;
      tick_cnt_q <= tick_cnt_d;
      pending_q  <= pending_d;
      // Commit samples the registered pending value, so a step landing in
      // the same cycle shows up only at the following frame_start.
      if (bus.frame_start) scroll_off_q <= pending_q;
    end
  end

  // S1: downscale and apply the offset. Rows that are out of the image are
  // flagged invalid, so the single-subtract wrap only has to be right for
  // in-range rows.
  always_comb begin
    xdown   = bus.DrawX >> SHIFT;
    ydown   = bus.DrawY >> SHIFT;
    row_sum = {1'b0, ydown} + {2'b00, scroll_off_q};
    row_w   = (row_sum >= C_IMGH11) ? 9'(row_sum - C_IMGH11) : row_sum[8:0];
    v1_w    = bus.pix_valid & (xdown < C_IMGW10) & (ydown < C_IMGH10);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      col_q        <= '0;
      row_q        <= '0;
      v1_q         <= 1'b0;
      bg_addr_q    <= '0;
      addr_valid_q <= 1'b0;
    end else begin
      col_q        <= xdown;
      row_q        <= row_w;
      v1_q         <= v1_w;
      // S2: linear address; held when the pixel is not valid.
      if (v1_q) bg_addr_q <= ADDR_W'(row_q) * C_IMGW_A + ADDR_W'(col_q);
      addr_valid_q <= v1_q;
    end
  end

  assign bus.bg_addr    = bg_addr_q;
  assign bus.addr_valid = addr_valid_q;
  assign bus.scroll_off = scroll_off_q;

endmodule
`default_nettype wire

// File: tb/tb_bg_scroll_addr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bg_scroll_addr
//  Description : Directed self-checking bench for bg_scroll_addr with default
//                parameters (320x240, SHIFT=1, STEP=1, TICKS_PER_STEP=2).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bg_scroll_addr;

  logic Clk;
  logic Reset;
  int   checks;
  int   errors;

  bg_scroll_addr_if #(.ADDR_W(17)) bus ();

  bg_scroll_addr #(
    .IMG_W(320), .IMG_H(240), .SHIFT(1), .STEP(1),
    .TICKS_PER_STEP(2), .ADDR_W(17)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_bg(input int n);
    for (int i = 0; i < n; i++) begin
      bus.BG_EN = 1'b1; step();
      bus.BG_EN = 1'b0; step();
    end
  endtask

  task automatic frame();
    bus.frame_start = 1'b1; step();
    bus.frame_start = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset           = 1'b1;
    bus.BG_EN       = 1'b0;
    bus.scroll_run  = 1'b1;
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
    bus.DrawX       = '0;
    bus.DrawY       = '0;
    step(); step();
    Reset = 1'b0;
    check("rst_bg_addr",    32'(bus.bg_addr),    32'd0);
    check("rst_addr_valid", 32'(bus.addr_valid), 32'd0);
    check("rst_scroll_off", 32'(bus.scroll_off), 32'd0);

    // Edges while IDLE are ignored; first frame_start commits 0 and enters RUN.
    pulse_bg(3);
    frame();
    check("idle_commit", 32'(bus.scroll_off), 32'd0);

    // 4 edges -> 2 steps.
    pulse_bg(4);
    frame();
    check("four_edges", 32'(bus.scroll_off), 32'd2);

    // Level held 20 cycles counts once; one more edge completes a step.
    bus.BG_EN = 1'b1;
    repeat (20) step();
    bus.BG_EN = 1'b0;
    step();
    pulse_bg(1);
    frame();
    check("level_once", 32'(bus.scroll_off), 32'd3);

    // Freeze: HOLD ignores 6 edges.
    bus.scroll_run = 1'b0;
    step();
    pulse_bg(6);
    frame();
    bus.scroll_run = 1'b1;
    step();
    check("hold_frozen", 32'(bus.scroll_off), 32'd3);

    // Step coinciding with frame_start: old value first, new value next frame.
    pulse_bg(1);
    bus.BG_EN = 1'b1; bus.frame_start = 1'b1;
    step();
    bus.BG_EN = 1'b0; bus.frame_start = 1'b0;
    check("coincide_old", 32'(bus.scroll_off), 32'd3);
    step();
    frame();
    check("coincide_new", 32'(bus.scroll_off), 32'd4);

    // Walk pending to 239, then one step wraps to 0.
    pulse_bg(470);
    frame();
    check("reach_239", 32'(bus.scroll_off), 32'd239);
    pulse_bg(2);
    frame();
    check("wrap_zero", 32'(bus.scroll_off), 32'd0);
    pulse_bg(10);
    frame();
    check("offset_5", 32'(bus.scroll_off), 32'd5);

    // DrawY=478 -> 239, +5 -> 244-240 = 4; DrawX=2 -> col 1; 4*320+1 = 1281.
    bus.DrawX = 10'd2; bus.DrawY = 10'd478; bus.pix_valid = 1'b1;
    step();
    bus.pix_valid = 1'b0;
    step();
    check("row_wrap_addr",  32'(bus.bg_addr),    32'd1281);
    check("row_wrap_valid", 32'(bus.addr_valid), 32'd1);

    // Reset with a valid pixel in S1.
    bus.DrawX = 10'd10; bus.DrawY = 10'd20; bus.pix_valid = 1'b1;
    step();
    Reset = 1'b1;
    step();
    check("midrst_valid", 32'(bus.addr_valid), 32'd0);
    check("midrst_off",   32'(bus.scroll_off), 32'd0);
    check("midrst_addr",  32'(bus.bg_addr),    32'd0);
    Reset = 1'b0; bus.pix_valid = 1'b0;
    step();
    // Back in IDLE: these edges must not count.
    pulse_bg(2);
    frame();
    frame();
    check("post_rst_idle", 32'(bus.scroll_off), 32'd0);

    // Pipeline, offset 0: (10,20) -> 10*320+5 = 3205.
    bus.DrawX = 10'd10; bus.DrawY = 10'd20; bus.pix_valid = 1'b1;
    step();
    check("lat1_valid", 32'(bus.addr_valid), 32'd0);
    bus.DrawX = 10'd700;
    step();
    check("addr_3205",  32'(bus.bg_addr),    32'd3205);
    check("valid_3205", 32'(bus.addr_valid), 32'd1);
    bus.DrawX = 10'd639; bus.DrawY = 10'd479;
    step();
    check("x700_invalid", 32'(bus.addr_valid), 32'd0);
    check("x700_hold",    32'(bus.bg_addr),    32'd3205);
    bus.DrawX = 10'd10; bus.DrawY = 10'd500;
    step();
    check("corner_addr",  32'(bus.bg_addr),    32'd76799);
    check("corner_valid", 32'(bus.addr_valid), 32'd1);
    bus.pix_valid = 1'b0;
    step();
    check("y500_invalid", 32'(bus.addr_valid), 32'd0);
    check("y500_hold",    32'(bus.bg_addr),    32'd76799);

    // RUN resumed after the post-reset frame_start.
    pulse_bg(2);
    frame();
    check("post_rst_run", 32'(bus.scroll_off), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
